regfile_wb_scoreboard: RTL and testbench

Parametrised register-file and write-back stage for the single-issue MIPS core. It is the successor to the single-cycle decode/register block. It adds:
- configurable data width and register count
- selectable destination register (rt/rd/link) and write-back source (ALU/memory/link address)
- three-mode immediate extension
- optional same-cycle write bypass
- a per-register pending-load scoreboard with a second write port for multi-cycle load returns, generating a decode stall

It sits between instruction decode and execute.

---
 rtl/regfile_wb_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_wb_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scoreboard.sv
// Register file and write-back stage with a pending-load scoreboard.
// Two write ports (primary write-back and multi-cycle load return),
// two combinational read ports with optional same-cycle bypass,
// immediate extension, and a decode stall for outstanding loads.
module regfile_wb_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int IMM_W    = 16,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        imm_mode,
  input  logic              reg_write,
  input  logic [1:0]        reg_dst,
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_addr,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_dest,
  input  logic              ld_return,
  input  logic [ADDR_W-1:0] ld_return_dest,
  input  logic [DATA_W-1:0] ld_return_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] imm_ext,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              stall
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic        BYP  = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [DATA_W-1:0] wb_data;
  logic              wr_en;
  logic              ld_en;
  logic              cov_rs;
  logic              cov_rt;

  // Resolve primary destination index and write-back data source
  always_comb begin
    wb_addr = rt;
    wb_data = alu_result;
    case (reg_dst)
      2'b01:   wb_addr = rd;
      2'b10:   wb_addr = ADDR_W'(LINK_REG);
      default: wb_addr = rt;
    endcase
    case (wb_sel)
      2'b01:   wb_data = mem_data;
      2'b10:   wb_data = link_addr;
      default: wb_data = alu_result;
    endcase
  end

  assign wr_en = reg_write && (wb_addr != '0);
  assign ld_en = ld_return && (ld_return_dest != '0);

  // Register array update; the primary write is placed last so that on an
  // index collision its non-blocking assignment overrides the load return
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[ADDR_W'(i)] <= '0;
    end else begin
      if (ld_en) regs[ld_return_dest] <= ld_return_data;
      if (wr_en) regs[wb_addr] <= wb_data;
    end
  end

  // Read port 1: zero register, then primary bypass, then load bypass
  always_comb begin
    read_data1 = regs[rs];
    if (rs == '0)                              read_data1 = '0;
    else if (BYP && wr_en && wb_addr == rs)    read_data1 = wb_data;
    else if (BYP && ld_en && ld_return_dest == rs) read_data1 = ld_return_data;
  end

  // Read port 2: same priority as port 1
  always_comb begin
    read_data2 = regs[rt];
    if (rt == '0)                              read_data2 = '0;
    else if (BYP && wr_en && wb_addr == rt)    read_data2 = wb_data;
    else if (BYP && ld_en && ld_return_dest == rt) read_data2 = ld_return_data;
  end

  // Scoreboard next state: issue is applied after return so a same-cycle
  // issue/return to one index leaves the bit set
  always_comb begin
    pending_nxt = pending;
    if (ld_return) pending_nxt[ld_return_dest] = 1'b0;
    if (ld_issue && ld_issue_dest != '0) pending_nxt[ld_issue_dest] = 1'b1;
  end

  // Scoreboard state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Stall when a source has an outstanding load not covered by bypass
  always_comb begin
    cov_rs = BYP && ld_return && (ld_return_dest == rs);
    cov_rt = BYP && ld_return && (ld_return_dest == rt);
    stall  = (pending[rs] && (rs != '0) && !cov_rs) ||
             (pending[rt] && (rt != '0) && !cov_rt);
  end

  generate
    if (IMM_W == DATA_W) begin : g_imm_pass
      assign imm_ext = imm_in;
    end else begin : g_imm_ext
      // Immediate extension: sign, zero, or upper placement
      always_comb begin
        case (imm_mode)
          2'b01:   imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm_in};
          2'b10:   imm_ext = {imm_in, {(DATA_W-IMM_W){1'b0}}};
          default: imm_ext = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};
        endcase
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: one bypassing and one
// non-bypassing instance share all inputs.
module tb_regfile_wb_scoreboard;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm_in;
  logic [1:0]  imm_mode, reg_dst, wb_sel;
  logic        reg_write, ld_issue, ld_return;
  logic [31:0] alu_result, mem_data, link_addr, ld_return_data;
  logic [4:0]  ld_issue_dest, ld_return_dest;

  logic [31:0] rd1_b, rd2_b, imm_b, rd1_n, rd2_n, imm_n;
  logic [4:0]  wba_b, wba_n;
  logic        stall_b, stall_n;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  regfile_wb_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .IMM_W(16), .BYPASS(1)
  ) dut (
    .clock(clock), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
    .imm_in(imm_in), .imm_mode(imm_mode), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_result(alu_result),
    .mem_data(mem_data), .link_addr(link_addr), .ld_issue(ld_issue),
    .ld_issue_dest(ld_issue_dest), .ld_return(ld_return),
    .ld_return_dest(ld_return_dest), .ld_return_data(ld_return_data),
    .read_data1(rd1_b), .read_data2(rd2_b), .imm_ext(imm_b),
    .wb_addr(wba_b), .stall(stall_b)
  );

  regfile_wb_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .IMM_W(16), .BYPASS(0)
  ) dut_nb (
    .clock(clock), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
    .imm_in(imm_in), .imm_mode(imm_mode), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_result(alu_result),
    .mem_data(mem_data), .link_addr(link_addr), .ld_issue(ld_issue),
    .ld_issue_dest(ld_issue_dest), .ld_return(ld_return),
    .ld_return_dest(ld_return_dest), .ld_return_data(ld_return_data),
    .read_data1(rd1_n), .read_data2(rd2_n), .imm_ext(imm_n),
    .wb_addr(wba_n), .stall(stall_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    reg_write = 1'b0;
    ld_issue  = 1'b0;
    ld_return = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs = 5'd5; rt = 5'd31; rd = '0;
    imm_in = '0; imm_mode = '0; reg_dst = '0; wb_sel = '0;
    reg_write = 0; ld_issue = 0; ld_return = 0;
    alu_result = '0; mem_data = '0; link_addr = '0; ld_return_data = '0;
    ld_issue_dest = '0; ld_return_dest = '0;

    // Reset state
    #2;
    chk("rst_rd1", rd1_b, 32'h0);
    chk("rst_rd2", rd2_b, 32'h0);
    chk("rst_stall", {31'b0, stall_b}, 32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_rd1", rd1_b, 32'h0);
    chk("post_rst_rd2_nb", rd2_n, 32'h0);

    // ALU write to rd=8, bypass vs no bypass
    reg_write = 1; reg_dst = 2'b01; rd = 5'd8; wb_sel = 2'b00;
    alu_result = 32'h1234_5678; rs = 5'd8; rt = 5'd0;
    #1;
    chk("wb_addr_rd", {27'b0, wba_b}, 32'd8);
    chk("byp_rd1", rd1_b, 32'h1234_5678);
    chk("nobyp_rd1_same", rd1_n, 32'h0);
    tick; idle;
    #1;
    chk("nobyp_rd1_next", rd1_n, 32'h1234_5678);
    chk("byp_rd1_next", rd1_b, 32'h1234_5678);

    // Link write to r31
    reg_write = 1; reg_dst = 2'b10; wb_sel = 2'b10; link_addr = 32'h0040_0010;
    #1;
    chk("wb_addr_link", {27'b0, wba_b}, 32'd31);
    tick; idle; rt = 5'd31;
    #1;
    chk("link_rd2", rd2_b, 32'h0040_0010);
    chk("link_rd2_nb", rd2_n, 32'h0040_0010);

    // Write to r0 discarded, never bypassed
    reg_write = 1; reg_dst = 2'b01; rd = 5'd0; wb_sel = 2'b11;
    alu_result = 32'hFFFF_FFFF; rs = 5'd0;
    #1;
    chk("r0_byp", rd1_b, 32'h0);
    tick; idle;
    #1;
    chk("r0_after", rd1_b, 32'h0);

    // Memory data to rt-selected destination (reg_dst=11)
    reg_write = 1; reg_dst = 2'b11; wb_sel = 2'b01; rt = 5'd10;
    mem_data = 32'hCAFE_F00D;
    #1;
    chk("wb_addr_rt", {27'b0, wba_b}, 32'd10);
    chk("mem_byp_rd2", rd2_b, 32'hCAFE_F00D);
    tick; idle;
    #1;
    chk("mem_rd2_nb", rd2_n, 32'hCAFE_F00D);

    // Load to r9: stall t1..t3, covered at t3 with bypass
    rt = 5'd0; rs = 5'd9; ld_issue = 1; ld_issue_dest = 5'd9;
    #1;
    chk("ld_t0_stall", {31'b0, stall_b}, 32'h0);
    tick; idle;
    #1;
    chk("ld_t1_stall", {31'b0, stall_b}, 32'h1);
    chk("ld_t1_stall_nb", {31'b0, stall_n}, 32'h1);
    tick;
    chk("ld_t2_stall", {31'b0, stall_b}, 32'h1);
    tick;
    ld_return = 1; ld_return_dest = 5'd9; ld_return_data = 32'hDEAD_BEEF;
    #1;
    chk("ld_t3_stall", {31'b0, stall_b}, 32'h0);
    chk("ld_t3_rd1", rd1_b, 32'hDEAD_BEEF);
    chk("ld_t3_stall_nb", {31'b0, stall_n}, 32'h1);
    chk("ld_t3_rd1_nb", rd1_n, 32'h0);
    tick; idle;
    #1;
    chk("ld_t4_stall_nb", {31'b0, stall_n}, 32'h0);
    chk("ld_t4_rd1_nb", rd1_n, 32'hDEAD_BEEF);

    // Stall through the rt port
    rs = 5'd0; rt = 5'd12; ld_issue = 1; ld_issue_dest = 5'd12;
    tick; idle;
    #1;
    chk("rt_stall", {31'b0, stall_b}, 32'h1);
    ld_return = 1; ld_return_dest = 5'd12; ld_return_data = 32'h0000_0C0C;
    tick; idle; rt = 5'd0;

    // Primary and load return collide on r4: primary wins, pending cleared
    ld_issue = 1; ld_issue_dest = 5'd4;
    tick; idle;
    rs = 5'd4;
    ld_return = 1; ld_return_dest = 5'd4; ld_return_data = 32'hAAAA_AAAA;
    reg_write = 1; reg_dst = 2'b01; rd = 5'd4; wb_sel = 2'b00;
    alu_result = 32'h5555_5555;
    #1;
    chk("coll_byp_rd1", rd1_b, 32'h5555_5555);
    tick; idle;
    #1;
    chk("coll_rd1_nb", rd1_n, 32'h5555_5555);
    chk("coll_stall", {31'b0, stall_b}, 32'h0);
    chk("coll_stall_nb", {31'b0, stall_n}, 32'h0);

    // Same-cycle issue and return on r6 keeps pending
    ld_issue = 1; ld_issue_dest = 5'd6;
    tick; idle;
    rs = 5'd6;
    ld_issue = 1; ld_issue_dest = 5'd6;
    ld_return = 1; ld_return_dest = 5'd6; ld_return_data = 32'h1111_2222;
    #1;
    chk("iss_ret_stall_byp", {31'b0, stall_b}, 32'h0);
    chk("iss_ret_stall_nb", {31'b0, stall_n}, 32'h1);
    tick; idle;
    #1;
    chk("iss_ret_pending", {31'b0, stall_b}, 32'h1);
    chk("iss_ret_rd1", rd1_n, 32'h1111_2222);
    ld_return = 1; ld_return_dest = 5'd6; ld_return_data = 32'h3333_4444;
    tick; idle;

    // Primary write to a pending register does not clear it
    ld_issue = 1; ld_issue_dest = 5'd7;
    tick; idle;
    reg_write = 1; reg_dst = 2'b01; rd = 5'd7; alu_result = 32'h0000_0077;
    tick; idle; rs = 5'd7;
    #1;
    chk("wr_pend_stall", {31'b0, stall_b}, 32'h1);
    chk("wr_pend_rd1", rd1_b, 32'h0000_0077);

    // Issue to r0 ignored
    rs = 5'd0; rt = 5'd0; ld_issue = 1; ld_issue_dest = 5'd0;
    tick; idle;
    #1;
    chk("r0_no_pend", {31'b0, stall_b}, 32'h0);

    // Immediate extension
    imm_in = 16'h8001;
    imm_mode = 2'b00; #1; chk("imm_sign", imm_b, 32'hFFFF_8001);
    imm_mode = 2'b01; #1; chk("imm_zero", imm_b, 32'h0000_8001);
    imm_mode = 2'b10; #1; chk("imm_upper", imm_b, 32'h8001_0000);
    imm_mode = 2'b11; #1; chk("imm_mode3", imm_b, 32'hFFFF_8001);
    imm_in = 16'h1234;
    imm_mode = 2'b00; #1; chk("imm_sign_pos", imm_n, 32'h0000_1234);

    // Asynchronous reset in the middle of a write sequence
    reg_write = 1; reg_dst = 2'b01; rd = 5'd8; alu_result = 32'h9999_9999;
    tick;
    rst_n = 1'b0; reg_write = 0; rs = 5'd8; rt = 5'd31;
    #1;
    chk("arst_rd1", rd1_b, 32'h0);
    chk("arst_rd2", rd2_b, 32'h0);
    chk("arst_rd1_nb", rd1_n, 32'h0);
    rs = 5'd7;
    #1;
    chk("arst_stall", {31'b0, stall_b}, 32'h0);
    chk("arst_wb_addr", {27'b0, wba_b}, 32'd8);
    tick;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
